// File: rtl/rsa_core_arbiter_if.sv
// Request/response and core-side bus of the shared RSA core arbiter.
// master: requesters plus the RSA core (drive requests, core results)
// slave : the arbiter itself
interface rsa_core_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int KEY_W   = 256,
   parameter int PRIME_W = 128,
   parameter int MSG_W   = 256
);
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*KEY_W-1:0]   req_key;
   logic [NUM_REQ*PRIME_W-1:0] req_p1;
   logic [NUM_REQ*PRIME_W-1:0] req_p2;
   logic [NUM_REQ*MSG_W-1:0]   req_msg;
   logic [NUM_REQ-1:0]         rsp_valid;
   logic [MSG_W-1:0]           rsp_data;
   logic                       rsp_err;
   logic [KEY_W-1:0]           core_key;
   logic [PRIME_W-1:0]         core_p1;
   logic [PRIME_W-1:0]         core_p2;
   logic [MSG_W-1:0]           core_msg;
   logic                       core_start;
   logic [MSG_W-1:0]           core_data;
   logic                       core_done;
   logic                       busy;
   logic [2:0]                 grant_id;

   modport master (
      output req_valid, req_key, req_p1, req_p2, req_msg, core_data, core_done,
      input  req_ready, rsp_valid, rsp_data, rsp_err, core_key, core_p1, core_p2,
             core_msg, core_start, busy, grant_id
   );

   modport slave (
      input  req_valid, req_key, req_p1, req_p2, req_msg, core_data, core_done,
      output req_ready, rsp_valid, rsp_data, rsp_err, core_key, core_p1, core_p2,
             core_msg, core_start, busy, grant_id
   );
endinterface

// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter sharing one RSA core between NUM_REQ requesters.
// One transaction at a time: accept, run the core with a timeout guard,
// strobe the result back to the owner, then wait for core_done to drop.
module rsa_core_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int KEY_W   = 256,
   parameter int PRIME_W = 128,
   parameter int MSG_W   = 256,
   parameter int TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              reset,
   rsa_core_arbiter_if.slave bus
);
   localparam int          IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [2:0]           last_q, grant_q, win_idx;
   logic                 win_found;
   logic [15:0]          cnt_q;
   logic [KEY_W-1:0]     key_q;
   logic [PRIME_W-1:0]   p1_q, p2_q;
   logic [MSG_W-1:0]     msg_q, rsp_data_q;
   logic                 rsp_err_q;
   logic [NUM_REQ-1:0]   ready;
   logic                 accept;
   logic                 run_end;
   int                   j;

   // Round-robin search starting just after the last granted requester
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      j         = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = int'(last_q) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!win_found && bus.req_valid[j[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = 3'(j);
         end
      end
   end

   // Grant only from IDLE with the core quiet; a stale done blocks new work
   always_comb begin
      ready = '0;
      if (!reset && state_q == IDLE && !bus.core_done && win_found)
         ready = NUM_REQ'(1) << win_idx;
   end

   assign accept  = |(bus.req_valid & ready);
   assign run_end = bus.core_done || (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: done beats timeout when both land in the same RUN cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)         state_d = RUN;
         RUN:     if (run_end)        state_d = RESP;
         RESP:                        state_d = DRAIN;
         DRAIN:   if (!bus.core_done) state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Operand latch, grant bookkeeping, run counter and result capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_q      <= '0;
         p1_q       <= '0;
         p2_q       <= '0;
         msg_q      <= '0;
         grant_q    <= '0;
         last_q     <= 3'(NUM_REQ - 1);
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else if (accept) begin
         key_q   <= bus.req_key[int'(win_idx)*KEY_W +: KEY_W];
         p1_q    <= bus.req_p1[int'(win_idx)*PRIME_W +: PRIME_W];
         p2_q    <= bus.req_p2[int'(win_idx)*PRIME_W +: PRIME_W];
         msg_q   <= bus.req_msg[int'(win_idx)*MSG_W +: MSG_W];
         grant_q <= win_idx;
         last_q  <= win_idx;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         cnt_q <= cnt_q + 16'd1;
         if (bus.core_done) begin
            rsp_data_q <= bus.core_data;
            rsp_err_q  <= 1'b0;
         end else if (cnt_q == CNT_LAST) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
         end
      end
   end

   assign bus.req_ready  = ready;
   assign bus.rsp_valid  = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.core_key   = key_q;
   assign bus.core_p1    = p1_q;
   assign bus.core_p2    = p2_q;
   assign bus.core_msg   = msg_q;
   assign bus.core_start = (state_q == RUN);
   assign bus.busy       = (state_q != IDLE);
   assign bus.grant_id   = grant_q;
endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Randomized bench for rsa_core_arbiter: behavioural core model, a
// transaction-level reference (round-robin pick, expected response cycle
// and value) and a per-cycle monitor comparing every output.
module tb_rsa_core_arbiter;
   localparam int NR = 4, KW = 64, PW = 32, MW = 64, TO = 20;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rsa_core_arbiter_if #(.NUM_REQ(NR), .KEY_W(KW), .PRIME_W(PW), .MSG_W(MW)) bus ();

   rsa_core_arbiter #(.NUM_REQ(NR), .KEY_W(KW), .PRIME_W(PW), .MSG_W(MW), .TIMEOUT(TO))
      dut (.clk(clk), .reset(reset), .bus(bus));

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // stimulus controls (written by main only)
   int              mode = 0;        // 0 quiet, 1 hold all high, 2 random
   int              force_lat = 0;   // 0 = random core latency
   int              force_hold = -1; // <0 = random done hold
   bit              spur_en = 1'b0;
   int              cmd_seq = 0;
   logic [NR-1:0]   cmd_mask = '0;
   logic [KW-1:0]   cmd_key [NR];
   logic [PW-1:0]   cmd_p1  [NR];
   logic [PW-1:0]   cmd_p2  [NR];
   logic [MW-1:0]   cmd_msg [NR];

   // reference model state (written by monitor only)
   int            m_last, m_gid, m_acc, m_rsp, last_lat;
   bit            m_free, m_out, m_drain, m_err, h_err;
   logic [KW-1:0] m_key;
   logic [PW-1:0] m_p1, m_p2;
   logic [MW-1:0] m_msg, m_data, h_data;
   int            n_acc = 0, n_done = 0;
   int            order_q[$];
   int            txn_lat = 1, txn_hold = 0;

   function automatic int rr_pick(input logic [NR-1:0] v, input int last);
      for (int k = 1; k <= NR; k++)
         if (v[(last + k) % NR]) return (last + k) % NR;
      return -1;
   endfunction

   // Core model: done after txn_lat start cycles, result = key ^ msg,
   // done held txn_hold cycles past start falling; optional spurious done.
   initial begin
      int run_cnt, hold_cnt, cur_hold;
      run_cnt = 0; hold_cnt = 0; cur_hold = 0;
      bus.core_done = 1'b0;
      bus.core_data = '0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            bus.core_done = 1'b0; run_cnt = 0; hold_cnt = 0;
         end else if (bus.core_start) begin
            run_cnt++;
            if (run_cnt == txn_lat) begin
               bus.core_done = 1'b1;
               bus.core_data = bus.core_key ^ bus.core_msg;
               cur_hold = txn_hold; hold_cnt = 0;
            end
         end else if (bus.core_done) begin
            run_cnt = 0;
            if (hold_cnt >= cur_hold) bus.core_done = 1'b0;
            else hold_cnt++;
         end else begin
            run_cnt = 0;
            if (spur_en && $urandom_range(0, 15) == 0) begin
               bus.core_done = 1'b1;
               bus.core_data = {$urandom, $urandom};
               cur_hold = $urandom_range(0, 4); hold_cnt = 0;
            end
         end
      end
   end

   // Requester driver: drops valid once accepted, applies commands/random traffic
   initial begin
      logic [NR-1:0] acc;
      int seen;
      seen = 0;
      bus.req_valid = '0; bus.req_key = '0; bus.req_p1 = '0; bus.req_p2 = '0; bus.req_msg = '0;
      forever begin
         @(negedge clk);
         acc = reset ? '0 : (bus.req_valid & bus.req_ready);
         @(posedge clk); #2;
         for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
               bus.req_valid[i] = 1'b0;
               if (mode == 1) begin
                  bus.req_key[i*KW +: KW] = {$urandom, $urandom};
                  bus.req_msg[i*MW +: MW] = {$urandom, $urandom};
                  bus.req_valid[i] = 1'b1;
               end
            end else if (mode == 2) begin
               if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
                  bus.req_key[i*KW +: KW] = {$urandom, $urandom};
                  bus.req_p1[i*PW +: PW]  = $urandom;
                  bus.req_p2[i*PW +: PW]  = $urandom;
                  bus.req_msg[i*MW +: MW] = {$urandom, $urandom};
                  bus.req_valid[i] = 1'b1;
               end else if (bus.req_valid[i] && $urandom_range(0, 19) == 0)
                  bus.req_valid[i] = 1'b0;
            end
         end
         if (cmd_seq != seen) begin
            seen = cmd_seq;
            for (int i = 0; i < NR; i++)
               if (cmd_mask[i]) begin
                  bus.req_key[i*KW +: KW] = cmd_key[i];
                  bus.req_p1[i*PW +: PW]  = cmd_p1[i];
                  bus.req_p2[i*PW +: PW]  = cmd_p2[i];
                  bus.req_msg[i*MW +: MW] = cmd_msg[i];
                  bus.req_valid[i] = 1'b1;
               end
         end
      end
   end

   // Monitor + reference: arbiter free after a quiet-done cycle post response;
   // result due min(lat,TO)+1 cycles after accept, error only when lat > TO.
   always @(negedge clk) begin
      logic [NR-1:0] er, ev;
      logic [MW-1:0] ed;
      logic          ee;
      int            w, lat;
      if (reset) begin
         m_last = NR - 1; m_gid = 0; m_free = 1'b1; m_out = 1'b0; m_drain = 1'b0;
         m_key = '0; m_p1 = '0; m_p2 = '0; m_msg = '0; h_data = '0; h_err = 1'b0;
         m_acc = 0; m_rsp = 0;
      end else begin
         er = '0;
         w  = rr_pick(bus.req_valid, m_last);
         if (m_free && !bus.core_done && w >= 0) er[w] = 1'b1;
         chk("req_ready", bus.req_ready, er);
         chk("busy", bus.busy, !m_free);
         chk("grant_id", bus.grant_id, m_gid);
         chk("core_key", bus.core_key, m_key);
         chk("core_p1", bus.core_p1, m_p1);
         chk("core_p2", bus.core_p2, m_p2);
         chk("core_msg", bus.core_msg, m_msg);
         chk("core_start", bus.core_start, m_out && cyc > m_acc && cyc < m_rsp);
         ev = '0; ed = h_data; ee = h_err;
         if (m_out && cyc == m_rsp) begin
            ev[m_gid] = 1'b1; ed = m_data; ee = m_err;
         end
         chk("rsp_valid", bus.rsp_valid, ev);
         chk("rsp_data", bus.rsp_data, ed);
         chk("rsp_err", bus.rsp_err, ee);
         if (m_out && cyc == m_rsp) begin
            m_out = 1'b0; m_drain = 1'b1; h_data = ed; h_err = ee;
            last_lat = cyc - m_acc; n_done++;
         end else if (m_drain && !bus.core_done) begin
            m_drain = 1'b0; m_free = 1'b1;
         end
         if (|er) begin
            lat = (force_lat > 0) ? force_lat : $urandom_range(1, TO + 5);
            txn_lat  = lat;
            txn_hold = (force_hold >= 0) ? force_hold : $urandom_range(0, 6);
            m_free = 1'b0; m_out = 1'b1; m_acc = cyc; m_gid = w; m_last = w;
            m_key = bus.req_key[w*KW +: KW];
            m_p1  = bus.req_p1[w*PW +: PW];
            m_p2  = bus.req_p2[w*PW +: PW];
            m_msg = bus.req_msg[w*MW +: MW];
            m_rsp  = cyc + 1 + ((lat < TO) ? lat : TO);
            m_err  = (lat > TO);
            m_data = m_err ? '0 : (m_key ^ m_msg);
            order_q.push_back(w);
            n_acc++;
         end
      end
   end

   task automatic issue(input logic [NR-1:0] mask, input logic [KW-1:0] k,
                        input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                        input logic [MW-1:0] msg);
      for (int i = 0; i < NR; i++)
         if (mask[i]) begin
            cmd_key[i] = k; cmd_p1[i] = p1; cmd_p2[i] = p2; cmd_msg[i] = msg;
         end
      cmd_mask = mask;
      cmd_seq++;
      @(posedge clk); #3;
   endtask

   task automatic wait_idle(input int budget);
      int b;
      b = 0;
      @(posedge clk);
      while (!(m_free && !m_out && bus.req_valid == '0) && b < budget) begin
         @(posedge clk); b++;
      end
      if (b >= budget) chk("idle_wait", {m_free, m_out}, 2'b10);
   endtask

   task automatic wait_acc(input int n, input int budget);
      int b;
      b = 0;
      while (n_acc < n && b < budget) begin
         @(posedge clk); b++;
      end
      if (n_acc < n) chk("acc_wait", n_acc, n);
   endtask

   task automatic do_reset();
      @(posedge clk); #3 reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      int base, tgt;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("rst_req_ready", bus.req_ready, '0);
      chk("rst_rsp_valid", bus.rsp_valid, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_core_start", bus.core_start, 1'b0);
      chk("rst_grant_id", bus.grant_id, 3'd0);
      chk("rst_core_key", bus.core_key, '0);
      chk("rst_rsp_data", bus.rsp_data, '0);
      chk("rst_rsp_err", bus.rsp_err, 1'b0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      // single request from requester 1
      force_lat = 10; force_hold = 0;
      base = order_q.size();
      issue(4'b0010, 64'd5, 32'd5, 32'd7, 64'h12);
      wait_idle(200);
      chk("single_grant", order_q[base], 1);
      chk("single_lat", last_lat, 11);
      chk("single_data", bus.rsp_data, 64'h17);
      chk("single_err", bus.rsp_err, 1'b0);

      // round robin with all requesters held high
      do_reset();
      force_lat = 3;
      base = order_q.size();
      tgt  = n_acc + 6;
      mode = 1;
      issue(4'b1111, 64'h1, 32'h2, 32'h3, 64'h4);
      wait_acc(tgt, 300);
      mode = 0;
      wait_idle(300);
      for (int k = 0; k < 6; k++) chk("rr_order", order_q[base + k], k % NR);

      // timeout, then a done landing on the last allowed RUN cycle
      do_reset();
      force_lat = 100;
      issue(4'b1000, 64'hAA, 32'h1, 32'h2, 64'h55);
      wait_idle(300);
      chk("to_lat", last_lat, TO + 1);
      chk("to_err", bus.rsp_err, 1'b1);
      chk("to_data", bus.rsp_data, '0);
      force_lat = TO;
      issue(4'b0001, 64'h1111, 32'h3, 32'h4, 64'h2222);
      wait_idle(300);
      chk("tie_lat", last_lat, TO + 1);
      chk("tie_err", bus.rsp_err, 1'b0);
      chk("tie_data", bus.rsp_data, 64'h3333);

      // done stuck high after the result while requester 2 waits
      force_lat = 2; force_hold = 5;
      base = order_q.size();
      issue(4'b0110, 64'h0F0F, 32'h9, 32'hB, 64'hF0F0);
      wait_idle(300);
      chk("stuck_first", order_q[base], 1);
      chk("stuck_second", order_q[base + 1], 2);

      // random traffic with random latency, hold and spurious done
      force_lat = 0; force_hold = -1; spur_en = 1'b1; mode = 2;
      tgt = n_done + 60;
      for (int b = 0; b < 20000 && n_done < tgt; b++) @(posedge clk);
      if (n_done < tgt) chk("rand_done", n_done, tgt);
      mode = 0; spur_en = 1'b0;
      wait_idle(500);

      // reset in the middle of a run
      do_reset();
      force_lat = 15; force_hold = 0;
      tgt = n_acc + 1;
      issue(4'b0100, 64'h77, 32'h1, 32'h1, 64'h70);
      wait_acc(tgt, 50);
      repeat (5) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rr_core_start", bus.core_start, 1'b0);
      chk("rr_busy", bus.busy, 1'b0);
      chk("rr_req_ready", bus.req_ready, '0);
      chk("rr_rsp_valid", bus.rsp_valid, '0);
      base = order_q.size();
      issue(4'b0101, 64'h77, 32'h1, 32'h1, 64'h70);
      @(posedge clk); #2 reset = 1'b0;
      wait_idle(300);
      chk("rr_first", order_q[base], 0);
      chk("rr_second", order_q[base + 1], 2);
      chk("rr_data", bus.rsp_data, 64'h07);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rsa_core_arbiter.md
Name: rsa_core_arbiter

Overview:
Shares one RSA encryption core (key / prime / message in, data_rdy start, ENCRY_DATA / ENCRY_RDY out) between NUM_REQ requesters. Accepts one request at a time under round-robin arbitration and latches its operands. It then sequences the core's start/done handshake, guards the run with a timeout, and returns the result to the requester that owns it. Sits between the crypto request clients and the single RSA_ALGORITHM instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
KEY_W, 256, encryption exponent width
PRIME_W, 128, width of each prime
MSG_W, 256, message / ciphertext width
TIMEOUT, 65535, max RUN cycles before abort (>=1, fits 16 bits)

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready
req_key  in  NUM_REQ*KEY_W  flattened exponents, slot i at [i*KEY_W +: KEY_W]
req_p1  in  NUM_REQ*PRIME_W  flattened prime 1
req_p2  in  NUM_REQ*PRIME_W  flattened prime 2
req_msg  in  NUM_REQ*MSG_W  flattened messages
rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe
rsp_data  out  MSG_W  result, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
core_key  out  KEY_W  to core Encryption_key
core_p1  out  PRIME_W  to core Prime_Number1
core_p2  out  PRIME_W  to core Prime_Number2
core_msg  out  MSG_W  to core MESSAGE
core_start  out  1  to core data_rdy (level)
core_data  in  MSG_W  from core ENCRY_DATA
core_done  in  1  from core ENCRY_RDY (level)
busy  out  1  high in any state except IDLE
grant_id  out  3  index of current/last granted requester

Behaviour:
- Reset (async, immediate): state=IDLE; req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, core_start=0, core_key/p1/p2/msg=0, busy=0, grant_id=0; round-robin pointer last=NUM_REQ-1 (requester 0 has first priority); cycle counter=0.
- States: IDLE, RUN, RESP, DRAIN.
- IDLE:
  - Winner = first asserted req_valid searching last+1, last+2, ... modulo NUM_REQ.
  - req_ready is combinational: one-hot on the winner only when state==IDLE and core_done==0; otherwise all zero.
  - On transfer: latch the winner's slice into core_key/p1/p2/msg registers; grant_id=winner; last=winner; counter=0; go to RUN.
  - No transfer: stay in IDLE.
- RUN:
  - core_start=1; operand registers held stable; counter increments each cycle.
  - core_done==1: capture rsp_data=core_data, rsp_err=0; go to RESP.
  - Else if counter==TIMEOUT-1: rsp_data=0, rsp_err=1; go to RESP.
  - core_done takes priority if both occur in the same cycle.
- RESP:
  - rsp_valid[grant_id]=1 for exactly this cycle; no backpressure.
  - core_start=0; go to DRAIN.
- DRAIN:
  - core_start=0; stay until core_done==0, then go to IDLE.
  - rsp_data and rsp_err hold their values until the next RESP.
- Latency: accept at cycle T; core_start high from T+1; core_done seen at cycle D; rsp_valid at D+1. Minimum accept-to-accept spacing is 4 cycles.
- Requests arriving during RUN/RESP/DRAIN wait; req_ready stays 0 for all requesters.
- A requester that deasserts req_valid before acceptance is simply skipped. There is no obligation to hold it.
- A core_done that is stale or stuck high blocks new grants. This guarantees each RUN starts with core_done low.
- Reset mid-operation aborts the transaction with no rsp_valid. The requester must reissue.
- Width rule: operands pass through unmodified; no arithmetic on data. The counter is 16 bits.

Test Plan:
- Single request: after reset, requester 1 issues key=5, p1=5, p2=7, msg=0x12; core model raises core_done after 10 cycles with 0x17. Required: req_ready=0010 for 1 cycle; core_key=5, core_p1=5, core_p2=7, core_msg=0x12 and core_start=1; rsp_valid=0010 for exactly 1 cycle, 11 cycles after accept; rsp_data=0x17, rsp_err=0.
- Round robin: all 4 req_valid held high, core done after 3 cycles each. Required: accept order 0,1,2,3,0,1; grant_id follows; no requester granted twice while another waits.
- Timeout: TIMEOUT=20, core_done never asserted. Required: core_start high 20 cycles; rsp_valid at the following cycle with rsp_err=1, rsp_data=0; return to IDLE; the next request is served normally.
- Stuck done: core model holds core_done high 5 cycles after the result while requester 2 is pending. Required: no req_ready until core_done falls; accept on the first IDLE cycle with core_done=0.
- Done/timeout tie: TIMEOUT=8, core_done asserted on the 8th RUN cycle. Required: rsp_err=0 and rsp_data=core_data.
- Reset in RUN: assert reset 5 cycles into RUN. Required: core_start, busy and req_ready go 0 immediately with no rsp_valid; after release, requester 0 (not the aborted one) has first priority; the reissued request completes with correct data.
